// File: rtl/prim_subreg_pkg.sv
// Shared types and helpers for software/hardware register fields.
package prim_subreg_pkg;

    // Software access modes a shadowed field may use.
    typedef enum logic [2:0] {
        SwRW  = 3'd0,
        SwWO  = 3'd1,
        SwW1C = 3'd2,
        SwW1S = 3'd3,
        SwW0C = 3'd4
    } sw_access_e;

    // Where the two-write sequence currently stands.
    typedef enum logic {
        PhaseFirst  = 1'b0,
        PhaseSecond = 1'b1
    } shadow_phase_e;

    // Access-mode names as they appear on the SWACCESS parameter.
    localparam logic [23:0] SwStrRW  = "RW";
    localparam logic [23:0] SwStrWO  = "WO";
    localparam logic [23:0] SwStrW1C = "W1C";
    localparam logic [23:0] SwStrW1S = "W1S";
    localparam logic [23:0] SwStrW0C = "W0C";

    // True for the modes a shadowed field supports. RO has nothing to
    // shadow, and RC cannot work because the read pulse resets the phase.
    function automatic bit sw_access_is_legal(logic [23:0] s);
        return (s == SwStrRW) || (s == SwStrWO) || (s == SwStrW1C) ||
               (s == SwStrW1S) || (s == SwStrW0C);
    endfunction

    // Map the SWACCESS name to its enum. Unknown names fall back to RW.
    // The field rejects them separately at elaboration.
    function automatic sw_access_e sw_access_decode(logic [23:0] s);
        sw_access_e mode;
        mode = SwRW;
        if (s == SwStrWO) begin
            mode = SwWO;
        end else if (s == SwStrW1C) begin
            mode = SwW1C;
        end else if (s == SwStrW1S) begin
            mode = SwW1S;
        end else if (s == SwStrW0C) begin
            mode = SwW0C;
        end
        return mode;
    endfunction

endpackage

// File: rtl/prim_subreg_arb.sv
// Software write-data arbiter: combines the write data with the current
// field value according to the field's access mode.
module prim_subreg_arb
    import prim_subreg_pkg::*;
#(
    parameter int unsigned DW       = 32,
    parameter logic [23:0] SWACCESS = "RW"
) (
    input  logic [DW-1:0] q,
    input  logic [DW-1:0] wd,
    output logic [DW-1:0] wr_data
);

    localparam sw_access_e SwAccess = sw_access_decode(SWACCESS);

    // Value that a software write would store in the field.
    always_comb begin
        // NOTE: wr_data gets a value before the case, so no mode can leave it
        // unassigned and infer a latch.
        wr_data = wd;
        unique case (SwAccess)
            SwW1C:   wr_data = q & ~wd;
            SwW1S:   wr_data = q | wd;
            SwW0C:   wr_data = q & wd;
            default: wr_data = wd;
        endcase
    end

endmodule

// File: rtl/prim_subreg_shadowed.sv
// Shadowed register field. Software must write the same value twice before
// it is committed. The committed copy is guarded by an inverted shadow copy,
// and any disagreement between the two raises a sticky storage error.
module prim_subreg_shadowed
    import prim_subreg_pkg::*;
#(
    parameter int unsigned     DW       = 32,
    parameter logic [23:0]     SWACCESS = "RW",
    parameter logic [DW-1:0]   RESVAL   = '0
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          re,
    input  logic          we,
    input  logic [DW-1:0] wd,
    input  logic          de,
    input  logic [DW-1:0] d,
    output logic          qe,
    output logic [DW-1:0] q,
    output logic [DW-1:0] qs,
    output logic          phase,
    output logic          err_update,
    output logic          err_storage
);

    localparam sw_access_e SwAccess = sw_access_decode(SWACCESS);

    // Reject configurations that cannot be built at all.
    if (!sw_access_is_legal(SWACCESS)) begin : gen_illegal_swaccess
        $error("prim_subreg_shadowed: SWACCESS must be RW, WO, W1C, W1S or W0C");
    end
    if (DW < 1 || DW > 32) begin : gen_illegal_dw
        $error("prim_subreg_shadowed: DW must be in 1..32");
    end

    logic [DW-1:0] wr_sw;
    logic [DW-1:0] staged_q;
    logic [DW-1:0] committed_q;
    logic [DW-1:0] shadow_q;
    logic          qe_q;
    logic          err_update_q;
    logic          err_storage_q;
    shadow_phase_e phase_q, phase_d;

    logic first_wr;
    logic second_wr;
    logic sw_commit;
    logic sw_mismatch;

    // Software write data is always derived from the committed value, so
    // W1C/W1S/W0C act on what hardware actually sees.
    prim_subreg_arb #(
        .DW       (DW),
        .SWACCESS (SWACCESS)
    ) u_arb (
        .q       (committed_q),
        .wd      (wd),
        .wr_data (wr_sw)
    );

    assign first_wr    = we && (phase_q == PhaseFirst);
    assign second_wr   = we && (phase_q == PhaseSecond);
    assign sw_commit   = second_wr && (wr_sw == staged_q);
    assign sw_mismatch = second_wr && (wr_sw != staged_q);

    // Phase state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            phase_q <= PhaseFirst;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples the values from before the clock edge.
            phase_q <= phase_d;
        end
    end

    // Next phase: a write toggles the sequence; a read alone restarts it.
    always_comb begin
        phase_d = phase_q;
        if (first_wr) begin
            phase_d = PhaseSecond;
        end else if (second_wr) begin
            phase_d = PhaseFirst;
        end else if (re) begin
            phase_d = PhaseFirst;
        end
    end

    // Staged copy captures the first write of a pair and survives a mismatch.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            staged_q <= RESVAL;
        end else if (first_wr) begin
            staged_q <= wr_sw;
        end
    end

    // Committed value and its inverted shadow. Software wins over hardware.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            committed_q <= RESVAL;
            // NOTE: the shadow resets to ~RESVAL rather than '0 so the pair
            // is consistent straight out of reset.
            shadow_q    <= ~RESVAL;
        end else if (sw_commit) begin
            committed_q <= wr_sw;
            shadow_q    <= ~wr_sw;
        end else if (de) begin
            committed_q <= d;
            shadow_q    <= ~d;
        end
    end

    // Single-cycle event pulses for a commit and for a mismatched second write.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            qe_q         <= 1'b0;
            err_update_q <= 1'b0;
        end else begin
            qe_q         <= sw_commit;
            err_update_q <= sw_mismatch;
        end
    end

    // Storage error is sticky: once the copies disagree only reset clears it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_storage_q <= 1'b0;
        end else if (committed_q != ~shadow_q) begin
            err_storage_q <= 1'b1;
        end
    end

    assign q           = committed_q;
    assign qs          = (SwAccess == SwWO) ? '0 : committed_q;
    assign qe          = qe_q;
    assign phase       = phase_q;
    assign err_update  = err_update_q;
    assign err_storage = err_storage_q;

    // A mismatch always returns the phase to the first write, so a second
    // mismatch cannot follow on the next cycle.
    ErrUpdateNoRepeat_A: assert property (
        @(posedge clk_i) disable iff (!rst_ni) err_update |=> !err_update);

    // Commit and mismatch come from exclusive conditions on the same write.
    QeExcludesErrUpdate_A: assert property (
        @(posedge clk_i) disable iff (!rst_ni) qe |-> !err_update);

endmodule

// File: tb/tb_prim_subreg_shadowed.sv
// Self-checking bench for prim_subreg_shadowed: an RW field and a W1C field
// share one stimulus stream and are compared every cycle against a
// behavioural model of the two-write protocol.
module tb_prim_subreg_shadowed;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          re, we, de;
    logic [DW-1:0] wd, d;

    logic [DW-1:0] q_o  [2];
    logic [DW-1:0] qs_o [2];
    logic          qe_o [2];
    logic          ph_o [2];
    logic          eu_o [2];
    logic          es_o [2];

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    prim_subreg_shadowed #(
        .DW       (DW),
        .SWACCESS ("RW"),
        .RESVAL   (8'h5A)
    ) u_rw (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .re          (re),
        .we          (we),
        .wd          (wd),
        .de          (de),
        .d           (d),
        .qe          (qe_o[0]),
        .q           (q_o[0]),
        .qs          (qs_o[0]),
        .phase       (ph_o[0]),
        .err_update  (eu_o[0]),
        .err_storage (es_o[0])
    );

    prim_subreg_shadowed #(
        .DW       (DW),
        .SWACCESS ("W1C"),
        .RESVAL   (8'hFF)
    ) u_w1c (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .re          (re),
        .we          (we),
        .wd          (wd),
        .de          (de),
        .d           (d),
        .qe          (qe_o[1]),
        .q           (q_o[1]),
        .qs          (qs_o[1]),
        .phase       (ph_o[1]),
        .err_update  (eu_o[1]),
        .err_storage (es_o[1])
    );

    // ---------------- behavioural model ----------------
    // mode: 0 RW, 1 WO, 2 W1C, 3 W1S, 4 W0C
    int            mode   [2] = '{0, 2};
    logic [DW-1:0] resval [2] = '{8'h5A, 8'hFF};
    logic [DW-1:0] m_q      [2];
    logic [DW-1:0] m_staged [2];
    bit            m_pending[2];
    bit            m_qe     [2];
    bit            m_eu     [2];
    bit            m_es     [2];
    bit            inj      [2];

    function automatic logic [DW-1:0] sw_value(int md, logic [DW-1:0] cur,
                                               logic [DW-1:0] wdata);
        case (md)
            2:       return cur & ~wdata;
            3:       return cur | wdata;
            4:       return cur & wdata;
            default: return wdata;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_q[i]       = resval[i];
            m_staged[i]  = resval[i];
            m_pending[i] = 1'b0;
            m_qe[i]      = 1'b0;
            m_eu[i]      = 1'b0;
            m_es[i]      = 1'b0;
            inj[i]       = 1'b0;
        end
    endtask

    // Effect of one clock edge with the given inputs on the expected state.
    task automatic model_step(bit r, bit w, logic [DW-1:0] wdat, bit h,
                              logic [DW-1:0] hd);
        for (int i = 0; i < 2; i++) begin
            logic [DW-1:0] v;
            bit hw_applies;
            v          = sw_value(mode[i], m_q[i], wdat);
            hw_applies = h;
            m_qe[i]    = 1'b0;
            m_eu[i]    = 1'b0;
            if (inj[i]) begin
                m_es[i] = 1'b1;
                inj[i]  = 1'b0;
            end
            if (w && !m_pending[i]) begin
                m_staged[i]  = v;
                m_pending[i] = 1'b1;
            end else if (w) begin
                m_pending[i] = 1'b0;
                if (v == m_staged[i]) begin
                    m_q[i]     = v;
                    m_qe[i]    = 1'b1;
                    hw_applies = 1'b0;
                end else begin
                    m_eu[i] = 1'b1;
                end
            end else if (r) begin
                m_pending[i] = 1'b0;
            end
            if (hw_applies) m_q[i] = hd;
        end
    endtask

    // ---------------- checking ----------------
    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison of both fields against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                check($sformatf("q[%0d]", i), 32'(q_o[i]), 32'(m_q[i]));
                check($sformatf("qs[%0d]", i), 32'(qs_o[i]),
                      (mode[i] == 1) ? 32'd0 : 32'(m_q[i]));
                check($sformatf("qe[%0d]", i), 32'(qe_o[i]), 32'(m_qe[i]));
                check($sformatf("phase[%0d]", i), 32'(ph_o[i]), 32'(m_pending[i]));
                check($sformatf("err_update[%0d]", i), 32'(eu_o[i]), 32'(m_eu[i]));
                check($sformatf("err_storage[%0d]", i), 32'(es_o[i]), 32'(m_es[i]));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cycle(bit r, bit w, logic [DW-1:0] wdat, bit h,
                         logic [DW-1:0] hd);
        re = r; we = w; wd = wdat; de = h; d = hd;
        @(posedge clk);
        model_step(r, w, wdat, h, hd);
        #1;
        re = 1'b0; we = 1'b0; de = 1'b0;
    endtask

    task automatic do_reset();
        re = 1'b0; we = 1'b0; de = 1'b0; wd = '0; d = '0;
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    logic [DW-1:0] bad_shadow;
    logic [DW-1:0] last_wd;

    initial begin
        re = 1'b0; we = 1'b0; de = 1'b0; wd = '0; d = '0;
        model_reset();
        #2 chk_en = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset values.
        check("rst_q_rw", 32'(q_o[0]), 32'h5A);
        check("rst_phase_rw", 32'(ph_o[0]), 32'd0);
        check("rst_err_update", 32'(eu_o[0]), 32'd0);
        check("rst_err_storage", 32'(es_o[0]), 32'd0);
        check("rst_q_w1c", 32'(q_o[1]), 32'hFF);

        // Matching double write commits.
        cycle(0, 1, 8'h3C, 0, 8'h00);
        check("dbl_phase1", 32'(ph_o[0]), 32'd1);
        check("dbl_q_held", 32'(q_o[0]), 32'h5A);
        cycle(0, 1, 8'h3C, 0, 8'h00);
        check("dbl_q", 32'(q_o[0]), 32'h3C);
        check("dbl_phase0", 32'(ph_o[0]), 32'd0);
        check("dbl_qe", 32'(qe_o[0]), 32'd1);
        cycle(0, 0, 8'h00, 0, 8'h00);
        check("dbl_qe_once", 32'(qe_o[0]), 32'd0);

        // Mismatched second write.
        do_reset();
        cycle(0, 1, 8'h3C, 0, 8'h00);
        cycle(0, 1, 8'h3D, 0, 8'h00);
        check("mis_q", 32'(q_o[0]), 32'h5A);
        check("mis_err_update", 32'(eu_o[0]), 32'd1);
        check("mis_phase", 32'(ph_o[0]), 32'd0);
        check("mis_qe", 32'(qe_o[0]), 32'd0);
        cycle(0, 0, 8'h00, 0, 8'h00);
        check("mis_err_once", 32'(eu_o[0]), 32'd0);

        // A read between the writes restarts the sequence.
        cycle(0, 1, 8'h11, 0, 8'h00);
        cycle(1, 0, 8'h00, 0, 8'h00);
        check("re_phase", 32'(ph_o[0]), 32'd0);
        cycle(0, 1, 8'h11, 0, 8'h00);
        check("re_q", 32'(q_o[0]), 32'h5A);
        check("re_phase1", 32'(ph_o[0]), 32'd1);

        // W1C field, then hardware write during a pending first write.
        do_reset();
        cycle(0, 1, 8'h0F, 0, 8'h00);
        cycle(0, 1, 8'h0F, 0, 8'h00);
        check("w1c_q", 32'(q_o[1]), 32'hF0);
        cycle(0, 1, 8'h01, 0, 8'h00);
        cycle(0, 0, 8'h00, 1, 8'hAA);
        check("w1c_de_q", 32'(q_o[1]), 32'hAA);
        check("w1c_de_phase", 32'(ph_o[1]), 32'd1);

        // Corrupt the shadow copy of the RW field.
        do_reset();
        cycle(0, 0, 8'h00, 0, 8'h00);
        bad_shadow = ~m_q[0] ^ 8'h01;
        force u_rw.shadow_q = bad_shadow;
        inj[0] = 1'b1;
        cycle(0, 0, 8'h00, 0, 8'h00);
        check("inj_err_storage", 32'(es_o[0]), 32'd1);
        cycle(0, 0, 8'h00, 0, 8'h00);
        release u_rw.shadow_q;
        cycle(0, 1, 8'h77, 0, 8'h00);
        cycle(0, 1, 8'h77, 0, 8'h00);
        cycle(0, 0, 8'h00, 1, 8'h12);
        check("inj_sticky", 32'(es_o[0]), 32'd1);
        check("inj_other_clean", 32'(es_o[1]), 32'd0);
        do_reset();
        check("inj_reset_clears", 32'(es_o[0]), 32'd0);

        // Randomised traffic, including resets in the middle of a sequence.
        last_wd = 8'h00;
        for (int n = 0; n < 3000; n++) begin
            bit            r, w, h;
            logic [DW-1:0] wv, hv;
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                r  = ($urandom_range(0, 3) == 0);
                w  = ($urandom_range(0, 2) == 0);
                h  = ($urandom_range(0, 5) == 0);
                wv = ($urandom_range(0, 1) == 0) ? last_wd : 8'($urandom);
                hv = 8'($urandom);
                if (w) last_wd = wv;
                cycle(r, w, wv, h, hv);
            end
        end

        @(negedge clk);
        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
